// File: rtl/sq_ctrl_pkg.sv
// sq_ctrl_pkg: shared states, reset values and config clamps for the square animator.
package sq_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_FRAME, MOVE_X, MOVE_Y, COMMIT} state_t;
    localparam int RST_X = 220;
    localparam int RST_Y = 140;
    localparam logic [7:0] RST_SIZE = 8'd200;
    localparam logic signed [3:0] RST_STEP = 4'sd1;
    localparam int SIZE_MIN = 8;
    localparam int SIZE_MAX = 255;
    function automatic logic [7:0] clamp_size(input logic [7:0] s);
        int v;
        v = int'(s);
        return 8'(v < SIZE_MIN ? SIZE_MIN : v > SIZE_MAX ? SIZE_MAX : v);
    endfunction
    // -8 has no positive counterpart, so a bounce could not negate it
    function automatic logic signed [3:0] clamp_step(input logic [3:0] s);
        return (s == 4'b1000) ? -4'sd7 : $signed(s);
    endfunction
endpackage

// File: rtl/sq_axis_step.sv
// sq_axis_step: one-axis move with bounce off the 0 and limit edges.
module sq_axis_step #(
    parameter int CORDW = 10
) (
    input  logic [CORDW-1:0]  pos_i,
    input  logic signed [3:0] step_i,
    input  logic [7:0]        size_i,
    input  logic [CORDW-1:0]  limit_i,
    output logic [CORDW-1:0]  pos_o,
    output logic signed [3:0] step_o
);
    logic signed [CORDW+1:0] n, sz, lim, far;
    logic lo, hi;
    assign n   = $signed({2'b00, pos_i}) + $signed({{(CORDW-2){step_i[3]}}, step_i});
    assign sz  = $signed({{(CORDW-6){1'b0}}, size_i});
    assign lim = $signed({2'b00, limit_i});
    assign far = n + sz;
    assign lo  = n < 0;
    assign hi  = far > lim;
    assign pos_o  = (step_i == 4'sd0) ? pos_i : lo ? '0 : hi ? CORDW'(lim - sz) : n[CORDW-1:0];
    assign step_o = (step_i == 4'sd0 || !(lo || hi)) ? step_i : -step_i;
endmodule

// File: rtl/square_anim_ctrl.sv
// square_anim_ctrl: bounces a square once per frame, applying new configs only in blanking.
module square_anim_ctrl
    import sq_ctrl_pkg::*;
#(
    parameter int CORDW = 10,
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             run,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [7:0]       cfg_size,
    input  logic [3:0]       cfg_dx,
    input  logic [3:0]       cfg_dy,
    output logic [CORDW-1:0] sq_x,
    output logic [CORDW-1:0] sq_y,
    output logic [7:0]       sq_size,
    output logic             frame_tick,
    output logic             busy
);
    state_t state_q, state_d;
    logic frame_tick_q, pend_q, pend_d;
    logic [CORDW-1:0] x_q, x_d, y_q, y_d, nx_q, nx_d, ny_q, ny_d, step_pos, fit_x, fit_y;
    logic [7:0] size_q, size_d, psize_q, psize_d;
    logic signed [3:0] dx_q, dx_d, dy_q, dy_d, ndx_q, ndx_d, ndy_q, ndy_d;
    logic signed [3:0] pdx_q, pdx_d, pdy_q, pdy_d, step_dir;
    logic on_y;
    assign on_y = state_q == MOVE_Y;
    sq_axis_step #(.CORDW(CORDW)) u_step (
        .pos_i   (on_y ? y_q : x_q),
        .step_i  (on_y ? dy_q : dx_q),
        .size_i  (size_q),
        .limit_i (on_y ? CORDW'(V_RES) : CORDW'(H_RES)),
        .pos_o   (step_pos),
        .step_o  (step_dir)
    );
    // a freshly loaded size may push the square past the far edge
    assign fit_x = (int'(nx_q) + int'(psize_q) > H_RES) ? CORDW'(H_RES - int'(psize_q)) : nx_q;
    assign fit_y = (int'(ny_q) + int'(psize_q) > V_RES) ? CORDW'(V_RES - int'(psize_q)) : ny_q;
    assign cfg_ready  = state_q == IDLE || state_q == WAIT_FRAME;
    assign busy       = state_q == MOVE_X || state_q == MOVE_Y || state_q == COMMIT;
    assign frame_tick = frame_tick_q;
    assign sq_x       = x_q;
    assign sq_y       = y_q;
    assign sq_size    = size_q;
    always_comb begin
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        nx_d = nx_q;
        ny_d = ny_q;
        size_d = size_q;
        dx_d = dx_q;
        dy_d = dy_q;
        ndx_d = ndx_q;
        ndy_d = ndy_q;
        pend_d = pend_q;
        psize_d = psize_q;
        pdx_d = pdx_q;
        pdy_d = pdy_q;
        case (state_q)
            IDLE:       state_d = run ? WAIT_FRAME : IDLE;
            WAIT_FRAME: state_d = !run ? IDLE : frame_tick_q ? MOVE_X : WAIT_FRAME;
            MOVE_X: begin
                state_d = MOVE_Y;
                nx_d = step_pos;
                ndx_d = step_dir;
            end
            MOVE_Y: begin
                state_d = COMMIT;
                ny_d = step_pos;
                ndy_d = step_dir;
            end
            COMMIT: begin
                state_d = WAIT_FRAME;
                x_d = pend_q ? fit_x : nx_q;
                y_d = pend_q ? fit_y : ny_q;
                size_d = pend_q ? psize_q : size_q;
                dx_d = pend_q ? pdx_q : ndx_q;
                dy_d = pend_q ? pdy_q : ndy_q;
                pend_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (cfg_valid && cfg_ready) begin
            pend_d = 1'b1;
            psize_d = clamp_size(cfg_size);
            pdx_d = clamp_step(cfg_dx);
            pdy_d = clamp_step(cfg_dy);
        end
    end
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state_q <= IDLE;
            frame_tick_q <= 1'b0;
            x_q <= CORDW'(RST_X);
            y_q <= CORDW'(RST_Y);
            nx_q <= CORDW'(RST_X);
            ny_q <= CORDW'(RST_Y);
            size_q <= RST_SIZE;
            dx_q <= RST_STEP;
            dy_q <= RST_STEP;
            ndx_q <= RST_STEP;
            ndy_q <= RST_STEP;
            pend_q <= 1'b0;
            psize_q <= RST_SIZE;
            pdx_q <= RST_STEP;
            pdy_q <= RST_STEP;
        end else begin
            state_q <= state_d;
            frame_tick_q <= sx == '0 && sy == CORDW'(V_RES);
            x_q <= x_d;
            y_q <= y_d;
            nx_q <= nx_d;
            ny_q <= ny_d;
            size_q <= size_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
            ndx_q <= ndx_d;
            ndy_q <= ndy_d;
            pend_q <= pend_d;
            psize_q <= psize_d;
            pdx_q <= pdx_d;
            pdy_q <= pdy_d;
        end
    end
endmodule

// File: tb/tb_square_anim_ctrl.sv
// tb_square_anim_ctrl: directed checks of motion, bounces, config handshake and reset.
module tb_square_anim_ctrl;
    import sq_ctrl_pkg::*;
    localparam int CORDW = 10;
    localparam int V_RES = 480;
    logic clk_pix = 1'b0;
    logic rst_pix = 1'b1;
    logic [CORDW-1:0] sx = 10'd1;
    logic [CORDW-1:0] sy = 10'd0;
    logic run = 1'b0;
    logic cfg_valid = 1'b0;
    logic cfg_ready;
    logic [7:0] cfg_size = 8'd0;
    logic [3:0] cfg_dx = 4'd0;
    logic [3:0] cfg_dy = 4'd0;
    logic [CORDW-1:0] sq_x, sq_y;
    logic [7:0] sq_size;
    logic frame_tick, busy;
    int checks = 0;
    int errors = 0;
    square_anim_ctrl #(.CORDW(CORDW), .H_RES(640), .V_RES(V_RES)) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(sx), .sy(sy), .run(run),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_size(cfg_size),
        .cfg_dx(cfg_dx), .cfg_dy(cfg_dy), .sq_x(sq_x), .sq_y(sq_y),
        .sq_size(sq_size), .frame_tick(frame_tick), .busy(busy)
    );
    always #5 clk_pix = ~clk_pix;
    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic tick_now();
        @(negedge clk_pix);
        sx = '0;
        sy = 10'(V_RES);
        @(negedge clk_pix);
        sy = '0;
        sx = 10'd1;
        chk("frame_tick_high", frame_tick, 1);
    endtask
    task automatic send_cfg(input logic [7:0] s, input logic [3:0] dx, input logic [3:0] dy);
        @(negedge clk_pix);
        cfg_valid = 1'b1;
        cfg_size = s;
        cfg_dx = dx;
        cfg_dy = dy;
        @(negedge clk_pix);
        cfg_valid = 1'b0;
    endtask
    task automatic do_frame(input bit cfg_at_tick, input int ex, input int ey);
        int px;
        px = int'(sq_x);
        tick_now();
        if (cfg_at_tick) cfg_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_pix);
            cfg_valid = 1'b0;
            chk("busy_in_frame", busy, 1);
            chk("x_held_in_frame", sq_x, px);
            if (i == 0) chk("frame_tick_one_cycle", frame_tick, 0);
        end
        @(negedge clk_pix);
        chk("busy_done", busy, 0);
        chk("sq_x", sq_x, ex);
        chk("sq_y", sq_y, ey);
    endtask
    initial begin
        repeat (2) @(negedge clk_pix);
        chk("rst_x", sq_x, 220);
        chk("rst_y", sq_y, 140);
        chk("rst_size", sq_size, 200);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_tick", frame_tick, 0);
        chk("rst_pend", dut.pend_q, 0);
        rst_pix = 1'b0;
        run = 1'b1;
        @(negedge clk_pix);
        do_frame(0, 221, 141);
        // walk right to x=438 with dx=+5, then bounce off the right edge
        send_cfg(8'd200, 4'd7, 4'd0);
        do_frame(0, 222, 142);
        for (int i = 1; i <= 27; i++) do_frame(0, 222 + 7 * i, 142);
        send_cfg(8'd200, 4'd5, 4'd0);
        do_frame(0, 418, 142);
        chk("dx_5", dut.dx_q, 5);
        for (int i = 1; i <= 4; i++) do_frame(0, 418 + 5 * i, 142);
        do_frame(0, 440, 142);
        chk("right_bounce_dx", dut.dx_q, -5);
        chk("zero_dy_kept", dut.dy_q, 0);
        do_frame(0, 435, 142);
        // walk left to x=3 with dx=-7, then bounce off the left edge
        send_cfg(8'd200, 4'b1001, 4'd0);
        do_frame(0, 430, 142);
        for (int i = 1; i <= 61; i++) do_frame(0, 430 - 7 * i, 142);
        do_frame(0, 0, 142);
        chk("left_bounce_dx", dut.dx_q, 7);
        do_frame(0, 7, 142);
        // config offered on the frame_tick cycle lands in the same frame
        cfg_size = 8'hFF;
        cfg_dx = 4'b1000;
        cfg_dy = 4'b1000;
        do_frame(1, 14, 142);
        chk("tick_cfg_size", sq_size, 255);
        chk("tick_cfg_dx", dut.dx_q, -7);
        chk("tick_cfg_dy", dut.dy_q, -7);
        chk("tick_cfg_pend", dut.pend_q, 0);
        send_cfg(8'd3, 4'd1, 4'd1);
        do_frame(0, 7, 135);
        chk("size_min_clamp", sq_size, 8);
        // cfg_valid held through the busy phase is only taken back in WAIT_FRAME
        tick_now();
        @(negedge clk_pix);
        cfg_valid = 1'b1;
        cfg_size = 8'd100;
        cfg_dx = 4'd2;
        cfg_dy = 4'd2;
        for (int i = 0; i < 3; i++) begin
            chk("busy_ready_low", cfg_ready, 0);
            chk("busy_no_xfer", dut.pend_q, 0);
            @(negedge clk_pix);
        end
        chk("wait_ready_high", cfg_ready, 1);
        chk("wait_pend_before", dut.pend_q, 0);
        chk("held_x", sq_x, 8);
        @(negedge clk_pix);
        cfg_valid = 1'b0;
        chk("wait_pend_after", dut.pend_q, 1);
        do_frame(0, 9, 137);
        chk("held_cfg_size", sq_size, 100);
        // dropping run mid-frame still completes the frame, then idles
        tick_now();
        @(negedge clk_pix);
        run = 1'b0;
        repeat (3) @(negedge clk_pix);
        chk("run_fall_x", sq_x, 11);
        chk("run_fall_y", sq_y, 139);
        @(negedge clk_pix);
        chk("run_fall_idle", dut.state_q, IDLE);
        run = 1'b1;
        @(negedge clk_pix);
        // reset in MOVE_Y discards the frame and any pending config
        send_cfg(8'd50, 4'd3, 4'd3);
        tick_now();
        repeat (2) @(negedge clk_pix);
        chk("pre_rst_state", dut.state_q, MOVE_Y);
        rst_pix = 1'b1;
        #1;
        chk("mid_rst_state", dut.state_q, IDLE);
        chk("mid_rst_x", sq_x, 220);
        chk("mid_rst_y", sq_y, 140);
        chk("mid_rst_size", sq_size, 200);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cfg_ready, 1);
        chk("mid_rst_pend", dut.pend_q, 0);
        @(negedge clk_pix);
        rst_pix = 1'b0;
        @(negedge clk_pix);
        do_frame(0, 221, 141);
        chk("post_rst_size", sq_size, 200);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
